// File: rtl/if_stage.sv
// Generic FIFO with synchronous flush; head entry is visible combinationally.
// Latency: a push is visible at the head on the cycle after the write.
// Backpressure: none internally. Pushing while full is only legal if the same cycle pops.
module if_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_dat;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// RV32I fetch stage: owns the PC, issues imem requests, buffers responses for decode.
// Latency: request to decode-valid is imem latency + 1 cycle.
// Backpressure: requests stop when in-flight + buffered reaches DEPTH; decode stall holds the head.
module if_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [XLEN-1:0]  imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [31:0]      imem_rsp_data_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [31:0]      id_instr_o,
    output logic [XLEN-1:0]  id_pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } id_entry_t;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   tag_count;
    logic [CW:0]     occupancy;
    logic            req_hs;
    logic            rsp_push;
    logic            id_pop;
    logic            fifo_empty;
    logic            tag_empty;
    logic [XLEN-1:0] rsp_pc;
    id_entry_t       head;
    id_entry_t       last;
    id_entry_t       shown;

    // Buffered entries count against the fetch budget so a response never finds the FIFO full.
    assign occupancy        = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid_o = !rst && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = pc;
    assign req_hs           = imem_req_valid_o && imem_req_ready_i;
    assign rsp_push         = imem_rsp_valid_i && !redirect_i && (drop == '0);
    assign inflight_next    = inflight + CW'(req_hs) - CW'(imem_rsp_valid_i);

    assign id_valid_o = !fifo_empty;
    assign id_pop     = id_valid_o && id_ready_i;
    assign shown      = fifo_empty ? last : head;
    assign id_instr_o = shown.instr;
    assign id_pc_o    = shown.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC & ~XLEN'(3);
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_i) begin
                pc   <= redirect_pc_i & ~XLEN'(3);
                drop <= inflight_next;
            end else begin
                if (req_hs)
                    pc <= pc + XLEN'(4);
                if (imem_rsp_valid_i && (drop != '0))
                    drop <= drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= {{XLEN{1'b0}}, NOP_INSTR};
        else if (!fifo_empty)
            last <= head;
    end

    // Tags are popped by every response, dropped or not, so they stay aligned across redirects.
    if_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (req_hs),
        .push_dat (pc),
        .pop      (imem_rsp_valid_i),
        .head_dat (rsp_pc),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    if_fifo #(.W($bits(id_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .push     (rsp_push),
        .push_dat ({rsp_pc, imem_rsp_data_i}),
        .pop      (id_pop),
        .head_dat (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) imem_rsp_valid_i |-> !tag_empty);
    assert property (@(posedge clk) disable iff (rst)
        (inflight == tag_count) && (drop <= inflight) && (inflight <= CW'(DEPTH)));

endmodule

// File: tb/tb_if_stage.sv
// Fetch-stage bench: in-order imem model with random latency, epoch-based stream model.
module tb_if_stage;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;

    always #5 clk = ~clk;

    if_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          buffered = 0;
    int          n_dec = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_req_pc;
    logic [31:0] exp_dec_pc;
    logic [31:0] last_pc;
    logic [31:0] last_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        epoch++;
        buffered   = 0;
        exp_req_pc = 32'h0;
        exp_dec_pc = 32'h0;
        last_pc    = 32'h0;
        last_instr = NOP;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, then advance the model at posedge.
    task automatic tick(input bit rr, input bit idr, input bit redir, input logic [31:0] tgt);
        bit          rsp;
        bit          exp_req;
        bit          exp_id;
        bit          req_v;
        logic [31:0] req_a;
        req_t        r;
        imem_req_ready_i = rr;
        id_ready_i       = idr;
        redirect_i       = redir;
        redirect_pc_i    = tgt;
        rsp              = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? mem_word(pend[0].addr) : $urandom();
        #1;
        exp_req = !redir && ((pend.size() + buffered) < DEPTH);
        exp_id  = buffered > 0;
        req_v   = imem_req_valid_o;
        req_a   = imem_req_addr_o;
        check("req_valid", 32'(req_v), 32'(exp_req));
        if (exp_req && req_v)
            check("req_addr", req_a, exp_req_pc);
        check("id_valid", 32'(id_valid_o), 32'(exp_id));
        if (exp_id) begin
            last_pc    = exp_dec_pc;
            last_instr = mem_word(exp_dec_pc);
        end
        check("id_pc", id_pc_o, last_pc);
        check("id_instr", id_instr_o, last_instr);
        @(posedge clk);
        if (exp_id && idr) begin
            exp_dec_pc += 32'd4;
            buffered--;
            n_dec++;
        end
        if (rsp) begin
            if (pend[0].epoch == epoch && !redir)
                buffered++;
            void'(pend.pop_front());
        end
        if (req_v && rr) begin
            r.addr  = req_a;
            r.epoch = epoch;
            r.due   = cyc + int'($urandom_range(lat_max, lat_min));
            pend.push_back(r);
            exp_req_pc += 32'd4;
        end
        if (redir) begin
            epoch++;
            buffered   = 0;
            exp_req_pc = tgt & ~32'd3;
            exp_dec_pc = tgt & ~32'd3;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges so the async path is what gets observed.
    task automatic do_reset();
        #2;
        rst              = 1'b1;
        imem_rsp_valid_i = 1'b0;
        redirect_i       = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("rst_id_valid", 32'(id_valid_o), 32'd0);
        check("rst_id_instr", id_instr_o, NOP);
        check("rst_id_pc", id_pc_o, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] t;
        rst              = 1'b1;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
        id_ready_i       = 1'b0;
        do_reset();

        // Streaming with latency 1.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        // Decode stall, then release.
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        // imem ready toggling.
        for (int i = 0; i < 8; i++) tick(i[0] == 1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect with two fetches outstanding.
        lat_min = 3; lat_max = 3;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a response, then a second redirect.
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h100);
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Address wrap-around and an unaligned target.
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset with entries buffered behind a stalled decode.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic.
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            t = $urandom();
            if (i == 700) do_reset();
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, t);
        end
        check("progress", 32'(n_dec > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
